// File: rtl/vpl_alu_pkg.sv
// Shared definitions for the vpl_alu issue/writeback slice.
//   DATA_W            : ALU datapath width (fixed at 4)
//   REG_CNT / ADDR_W  : register file geometry
//   F_*               : ALU function-select codes
//   state_t           : issue-stage FSM states (HOLD exists only with VPL_ALU_PIPE_EN)
package vpl_alu_pkg;
  localparam int DATA_W  = 4;
  localparam int REG_CNT = 4;
  localparam int ADDR_W  = 2;

  localparam logic [3:0] F_PASS = 4'b0000;
  localparam logic [3:0] F_INC  = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_ADC  = 4'b0011;
  localparam logic [3:0] F_SUB  = 4'b0100;
  localparam logic [3:0] F_SBC  = 4'b0101;
  localparam logic [3:0] F_DEC  = 4'b0110;
  localparam logic [3:0] F_NOT  = 4'b1000;
  localparam logic [3:0] F_AND  = 4'b1010;
  localparam logic [3:0] F_OR   = 4'b1100;
  localparam logic [3:0] F_SHR  = 4'b1110;

`ifdef VPL_ALU_PIPE_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
`endif
endpackage

// File: rtl/vpl_alu_issue_if.sv
// Instruction and result handshakes of the vpl_alu issue stage.
//   master : instruction source / result sink (the environment)
//   slave  : the issue stage
interface vpl_alu_issue_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_func;
  logic [ADDR_W-1:0] instr_dst;
  logic [ADDR_W-1:0] instr_src;
  logic [DATA_W-1:0] instr_imm;
  logic              instr_use_imm;
  logic              instr_swap;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_dst;

  modport master (
    output instr_valid, instr_func, instr_dst, instr_src, instr_imm,
           instr_use_imm, instr_swap, res_ready,
    input  instr_ready, res_valid, res_data, res_dst
  );
  modport slave (
    input  instr_valid, instr_func, instr_dst, instr_src, instr_imm,
           instr_use_imm, instr_swap, res_ready,
    output instr_ready, res_valid, res_data, res_dst
  );
endinterface

// File: rtl/vpl_regfile.sv
// REG_CNT x DATA_W register file, async active-low reset to 0.
//   we/waddr/wdata     : single write port
//   raddr_a/rdata_a    : read port A (combinational)
//   raddr_b/rdata_b    : read port B (combinational)
//   dbg_sel/dbg_data   : debug read port (combinational)
module vpl_regfile #(
  parameter int DATA_W  = 4,
  parameter int REG_CNT = 4,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  logic [REG_CNT-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/vpl_alu_issue.sv
// Issue/writeback stage around an external combinational 4-bit ALU.
// Accepts one instruction in IDLE, drives the ALU from registers during
// EXEC, writes result/carry/zero back and offers the result in RESP.
//   clk, rst_n               : clock, async active-low reset
//   io (slave)               : instruction and result handshakes
//   alu_operand_a/b, alu_func_sel : registered ALU drive
//   alu_result, alu_cout     : ALU outputs (combinational)
//   flag_c, flag_z           : carry / zero flags
//   dbg_sel, dbg_data        : debug register read
// Optional: define VPL_ALU_PIPE_EN to add a HOLD stage that registers the
// ALU outputs before writeback (latency k+3 instead of k+2).
module vpl_alu_issue import vpl_alu_pkg::*; #(
  parameter int DATA_W  = 4,
  parameter int REG_CNT = 4,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vpl_alu_issue_if.slave    io,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [3:0]        alu_func_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  state_t            state;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] rd_a, rd_b, a_src, b_src, wb_data;
  logic              wb_c, wb_en;

  vpl_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(wb_en), .waddr(dst_q), .wdata(wb_data),
    .raddr_a(io.instr_dst), .rdata_a(rd_a),
    .raddr_b(io.instr_src), .rdata_b(rd_b),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  assign a_src = rd_a;
  assign b_src = io.instr_use_imm ? io.instr_imm : rd_b;

`ifdef VPL_ALU_PIPE_EN
  logic [DATA_W-1:0] stg_res;
  logic              stg_c;
  assign wb_data = stg_res;
  assign wb_c    = stg_c;
  assign wb_en   = (state == S_HOLD);
`else
  assign wb_data = alu_result;
  assign wb_c    = alu_cout;
  assign wb_en   = (state == S_EXEC);
`endif

  // Gated with rst_n so nothing is offered while reset is held.
  assign io.instr_ready = rst_n && (state == S_IDLE);

  // The ALU drive registers hold func and operands; only dst is needed
  // past capture, so it is the only other field kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dst_q         <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_func_sel  <= '0;
      io.res_valid  <= 1'b0;
      io.res_data   <= '0;
      io.res_dst    <= '0;
      flag_c        <= 1'b0;
      flag_z        <= 1'b0;
`ifdef VPL_ALU_PIPE_EN
      stg_res       <= '0;
      stg_c         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (io.instr_valid) begin
          alu_operand_a <= io.instr_swap ? b_src : a_src;
          alu_operand_b <= io.instr_swap ? a_src : b_src;
          alu_func_sel  <= io.instr_func;
          dst_q         <= io.instr_dst;
          state         <= S_EXEC;
        end
`ifdef VPL_ALU_PIPE_EN
        S_EXEC: begin
          stg_res <= alu_result;
          stg_c   <= alu_cout;
          state   <= S_HOLD;
        end
        S_HOLD: begin
`else
        S_EXEC: begin
`endif
          flag_c       <= wb_c;
          flag_z       <= (wb_data == '0);
          io.res_data  <= wb_data;
          io.res_dst   <= dst_q;
          io.res_valid <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: if (io.res_ready) begin
          io.res_valid <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vpl_alu_issue.sv
// Scoreboard bench for vpl_alu_issue; models the external ALU and the
// register file, queues expected results at issue and checks them on output.
module tb_vpl_alu_issue;
  import vpl_alu_pkg::*;

`ifdef VPL_ALU_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpl_alu_issue_if #(.DATA_W(4), .ADDR_W(2)) bus ();

  logic [3:0] op_a, op_b, fsel, alu_res, dbg_data;
  logic       alu_c, flag_c, flag_z;
  logic [1:0] dbg_sel;

  vpl_alu_issue #(.DATA_W(4), .REG_CNT(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus),
    .alu_operand_a(op_a), .alu_operand_b(op_b), .alu_func_sel(fsel),
    .alu_result(alu_res), .alu_cout(alu_c),
    .flag_c(flag_c), .flag_z(flag_z),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Reference 4-bit ALU: {cout, result}. SUB carry means "no borrow".
  function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b, logic [3:0] f);
    case (f)
      F_PASS:  return {1'b0, a};
      F_INC:   return {1'b0, a} + 5'd1;
      F_ADD:   return {1'b0, a} + {1'b0, b};
      F_SUB:   return {1'b0, a} + {1'b0, ~b} + 5'd1;
      F_NOT:   return {1'b0, ~a};
      F_AND:   return {1'b0, a & b};
      F_OR:    return {1'b0, a | b};
      F_SHR:   return {a[0], 1'b0, a[3:1]};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_c, alu_res} = alu_f(op_a, op_b, fsel);

  typedef struct { int data; int dst; int c; int z; } exp_t;
  exp_t q[$];
  int   mdl[4];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, mdl[i]);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance (EXEC).
  task automatic issue(input logic [3:0] f, input int dst, input int src,
                       input int imm, input bit use_imm, input bit swap);
    int a_src, b_src, ea, eb, n;
    logic [4:0] r;
    exp_t e;
    a_src = mdl[dst];
    b_src = use_imm ? imm : mdl[src];
    ea = swap ? b_src : a_src;
    eb = swap ? a_src : b_src;
    r = alu_f(4'(ea), 4'(eb), f);
    e.data = int'(r[3:0]); e.c = int'(r[4]); e.z = (r[3:0] == 4'd0) ? 1 : 0; e.dst = dst;
    q.push_back(e);
    mdl[dst] = int'(r[3:0]);

    n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 0, 1);
    bus.instr_func = f;
    bus.instr_dst = 2'(dst);
    bus.instr_src = 2'(src);
    bus.instr_imm = 4'(imm);
    bus.instr_use_imm = use_imm;
    bus.instr_swap = swap;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("func", fsel, f);
    chk("busy_ready", bus.instr_ready, 0);
  endtask

  task automatic wait_result(input int stall);
    int n;
    exp_t e;
    n = 1;
    while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, LAT);
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    chk("res_data", bus.res_data, e.data);
    chk("res_dst", bus.res_dst, e.dst);
    chk("flag_c", flag_c, e.c);
    chk("flag_z", flag_z, e.z);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_data", bus.res_data, e.data);
      chk("bp_ready", bus.instr_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", bus.res_valid, 0);
    chk("post_ready", bus.instr_ready, 1);
    check_regs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0; bus.instr_func = '0; bus.instr_dst = '0;
    bus.instr_src = '0; bus.instr_imm = '0; bus.instr_use_imm = 1'b0;
    bus.instr_swap = 1'b0; bus.res_ready = 1'b1; dbg_sel = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_res_data", bus.res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_regs();
    chk("init_c", flag_c, 0);
    chk("init_z", flag_z, 0);
    chk("init_valid", bus.res_valid, 0);
    chk("init_ready", bus.instr_ready, 1);

    issue(F_PASS, 1, 0, 9, 1, 1); wait_result(0);  // load R1=9
    issue(F_ADD,  1, 0, 8, 1, 0); wait_result(0);  // 9+8 -> 1, carry
    issue(F_PASS, 2, 0, 0, 1, 1); wait_result(0);  // load 0 -> zero flag
    issue(F_PASS, 0, 0, 6, 1, 1); wait_result(0);  // R0=6
    issue(F_ADD,  0, 1, 0, 0, 0); wait_result(0);  // R0+R1 = 7
    issue(F_SUB,  1, 0, 0, 0, 1); wait_result(0);  // swapped: R0-R1 = 6

    bus.res_ready = 1'b0;                           // backpressure
    issue(F_OR,   2, 0, 0, 0, 0); wait_result(5);

    // Reset during EXEC abandons the load of 5 into R3.
    issue(F_PASS, 3, 0, 5, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.res_valid, 0);
    chk("abort_ready", bus.instr_ready, 0);
    void'(q.pop_back());
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_res", bus.res_valid, 0);
    end
    check_regs();

    issue(F_INC,  3, 0, 0, 0, 0); wait_result(0);  // R3 = 0+1

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vpl_alu_issue.md
Name: vpl_alu_issue

Overview:
- 4-bit register-file and issue/writeback stage wrapped around the combinational 4-bit ALU.
- Accepts one instruction per valid/ready handshake and reads operands from a 4-entry register file.
- Drives the ALU operand and function inputs from registers, samples the ALU result and carry-out, and writes them back to the register file and flags.
- Presents each result downstream through a valid/ready handshake.

Parameters:
- DATA_W, 4: datapath width. Fixed at 4 to match the ALU; any other value is unsupported.
- REG_CNT, 4: number of general registers.
- ADDR_W, 2: register index width, equal to log2(REG_CNT).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  stage can accept an instruction
- instr_func  in  4  ALU function select
- instr_dst  in  ADDR_W  destination register; also the default A source
- instr_src  in  ADDR_W  B source register
- instr_imm  in  DATA_W  immediate value
- instr_use_imm  in  1  1: B source is instr_imm instead of R[src]
- instr_swap  in  1  1: exchange the A and B operands
- alu_operand_a  out  DATA_W  to ALU
- alu_operand_b  out  DATA_W  to ALU
- alu_func_sel  out  4  to ALU
- alu_result  in  DATA_W  from ALU (combinational)
- alu_cout  in  1  from ALU
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_data  out  DATA_W  written-back value
- res_dst  out  ADDR_W  register that was written
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- dbg_sel  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  R[dbg_sel], combinational read

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All registers, flags and the instruction latch clear to 0.
  - alu_operand_a, alu_operand_b, alu_func_sel and res_data are 0; res_dst is 0.
  - res_valid is 0 and instr_ready is 0 while rst_n=0.
- State machine:
  - States are IDLE, EXEC and RESP, plus HOLD when VPL_ALU_PIPE_EN is defined.
- IDLE:
  - instr_ready=1.
  - On the edge where instr_valid&&instr_ready, latch all instruction fields, load the ALU drive registers, and go to EXEC.
- Operand selection, done at capture time:
  - a_src = R[dst]; b_src = use_imm ? imm : R[src].
  - If swap=1: alu_operand_a=b_src and alu_operand_b=a_src. Otherwise alu_operand_a=a_src and alu_operand_b=b_src.
  - alu_func_sel=func.
- Register read timing:
  - Operands are read from the register file state before any writeback on that same edge.
  - Back-to-back hazards cannot arise, because a new instruction is only accepted in IDLE.
- EXEC:
  - instr_ready=0. The ALU outputs are settled within this cycle.
  - At the end of the EXEC cycle:
    - R[dst] <= alu_result
    - flag_c <= alu_cout
    - flag_z <= (alu_result==0)
    - res_data <= alu_result
    - res_dst <= dst
    - res_valid <= 1
    - go to RESP.
  - Every function writes back, including pass-through functions.
- RESP:
  - res_valid=1, and res_data and res_dst are held stable until res_ready.
  - On res_valid&&res_ready, clear res_valid and go to IDLE.
  - Backpressure of any length is allowed.
- Latency and throughput:
  - Handshake accepted at edge k gives res_valid=1 after edge k+2.
  - Peak throughput is 1 instruction per 3 cycles with res_ready tied high.
- ALU drive registers keep their last values outside EXEC; they change only on instruction acceptance.
- Register-index wrap: dst and src are ADDR_W wide, so no out-of-range index exists.
- Reset mid-operation (in EXEC or RESP): the instruction is abandoned, with no writeback and no result delivered.
- dbg_data reflects the register contents after the most recent edge.

Optional Feature:
- Macro: VPL_ALU_PIPE_EN.
- Defined:
  - Adds a HOLD state between EXEC and RESP.
  - At the end of EXEC, alu_result and alu_cout are captured into staging registers.
  - Writeback, flags and res_valid update at the end of HOLD.
  - Latency is k+3 and peak throughput is 1 per 4 cycles.
  - This relaxes the ALU timing path.
- Undefined: the staging registers and HOLD state do not exist, and latency is k+2.

Decomposition:
- Shared package vpl_alu_pkg holds:
  - DATA_W and the function-code constants: F_PASS=0000, F_INC=0001, F_ADD=0010, F_ADC=0011, F_SUB=0100, F_SBC=0101, F_DEC=0110, F_NOT=1000, F_AND=1010, F_OR=1100, F_SHR=1110.
  - The state enum.
- One natural sub-module is vpl_regfile: REG_CNT x DATA_W, single write port, two read ports plus the debug read port, asynchronous-reset to 0.
- The ALU itself is instantiated by the parent; this block does not instantiate it.

Test Plan:
- Reset, then read dbg_sel=0..3 -> all 0; flag_c=0, flag_z=0, res_valid=0, instr_ready=1.
- Load: func=F_PASS, swap=1, use_imm=1, imm=9, dst=1, with res_ready=1 -> res_valid two cycles after acceptance; res_data=9, res_dst=1, flag_c=0, flag_z=0; R1=9.
- Add with carry out: R1=9, then func=F_ADD, use_imm=1, imm=8, dst=1 -> res_data=1, flag_c=1, flag_z=0; R1=1.
- Zero flag: load imm=0 into R2 -> res_data=0, flag_z=1.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stay stable, instr_ready=0; raise res_ready -> one transfer, then instr_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 during EXEC of a load of imm=5 into R3 -> R3 stays 0 and res_valid stays 0.
- With VPL_ALU_PIPE_EN defined: rerun the load scenario -> res_valid arrives one cycle later.
